// File: rtl/rng_mask_collect.sv
// Serial RNG bit collector producing W-bit mask words, with a
// repetition-count health test that latches a sticky failure.
//
// Ports:
//   clk        - single clock, rising edge
//   vrst       - asynchronous active-low reset
//   en         - collection enable
//   rng_in     - serial random bit from the generator
//   rd         - read strobe to the generator (high only while filling)
//   mask       - collected mask word
//   mask_valid - mask holds an unconsumed word
//   mask_ack   - consumer acknowledge (effective only while mask_valid)
//   rng_fail   - sticky health-test failure
module rng_mask_collect #(
    parameter int W         = 64,
    parameter int RCT_LIMIT = 16
) (
    input  logic         clk,
    input  logic         vrst,
    input  logic         en,
    input  logic         rng_in,
    output logic         rd,
    output logic [W-1:0] mask,
    output logic         mask_valid,
    input  logic         mask_ack,
    output logic         rng_fail
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = $clog2(RCT_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD,
        FAIL
    } state_t;

    state_t          state, state_n;
    logic [W-1:0]    sr, sr_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [RW-1:0]   run, run_n;
    logic [W-1:0]    mask_n;
    logic            mv_n;
    logic            fail_n;

    logic            ack;
    logic [W-1:0]    word;
    logic [RW-1:0]   run_inc;

    assign rd   = (state == FILL);
    assign ack  = mask_valid & mask_ack;
    assign word = {sr[W-2:0], rng_in};

    // run == 0 marks "no previous bit since IDLE"; saturate so it never wraps
    always_comb begin
        run_inc = RW'(1);
        if (run != '0 && rng_in == sr[0]) begin
            if (run == RW'(RCT_LIMIT)) run_inc = run;
            else                      run_inc = run + RW'(1);
        end
    end

    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        run_n   = run;
        mask_n  = mask;
        mv_n    = mask_valid;
        fail_n  = rng_fail;
        unique case (state)
            IDLE: begin
                if (ack) mv_n = 1'b0;
                if (en)  state_n = FILL;
            end
            FILL: begin
                if (!en) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    run_n   = '0;
                    if (ack) mv_n = 1'b0;
                end else begin
                    sr_n  = word;
                    run_n = run_inc;
                    if (run_inc == RW'(RCT_LIMIT)) begin
                        state_n = FAIL;
                        fail_n  = 1'b1;
                        mask_n  = '0;
                        mv_n    = 1'b0;
                    end else if (cnt == CW'(W - 1)) begin
                        cnt_n = '0;
                        if (!mask_valid || mask_ack) begin
                            mask_n = word;
                            mv_n   = 1'b1;
                        end else begin
                            state_n = HOLD;
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                        if (ack) mv_n = 1'b0;
                    end
                end
            end
            HOLD: begin
                // mask_valid is always 1 here, so mask_ack alone suffices
                if (mask_ack) begin
                    mask_n  = sr;
                    mv_n    = 1'b1;
                    state_n = en ? FILL : IDLE;
                    if (!en) run_n = '0;
                end
            end
            FAIL: begin
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge vrst) begin
        if (!vrst) begin
            state      <= IDLE;
            sr         <= '0;
            cnt        <= '0;
            run        <= '0;
            mask       <= '0;
            mask_valid <= 1'b0;
            rng_fail   <= 1'b0;
        end else begin
            state      <= state_n;
            sr         <= sr_n;
            cnt        <= cnt_n;
            run        <= run_n;
            mask       <= mask_n;
            mask_valid <= mv_n;
            rng_fail   <= fail_n;
        end
    end

endmodule

// File: tb/tb_rng_mask_collect.sv
// Randomized scoreboard bench for rng_mask_collect.
// Word order is checked at consumption; control outputs every cycle.
module tb_rng_mask_collect;

    localparam int W   = 64;
    localparam int LIM = 16;

    logic         clk = 1'b0;
    logic         vrst;
    logic         en;
    logic         rng_in;
    logic         rd;
    logic [W-1:0] mask;
    logic         mask_valid;
    logic         mask_ack;
    logic         rng_fail;

    rng_mask_collect #(.W(W), .RCT_LIMIT(LIM)) dut (
        .clk       (clk),
        .vrst      (vrst),
        .en        (en),
        .rng_in    (rng_in),
        .rd        (rd),
        .mask      (mask),
        .mask_valid(mask_valid),
        .mask_ack  (mask_ack),
        .rng_fail  (rng_fail)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] sb[$];

    // behavioural model: collection as a bit list, one output slot,
    // one pending completed word
    logic         m_fail, m_fill, m_hold;
    logic         bits[$];
    logic         m_valid;
    logic [W-1:0] m_word, m_held;
    int           m_run;
    logic         m_last;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fail  = 1'b0;
        m_fill  = 1'b0;
        m_hold  = 1'b0;
        bits.delete();
        m_valid = 1'b0;
        m_word  = '0;
        m_held  = '0;
        m_run   = 0;
        m_last  = 1'b0;
        sb.delete();
    endtask

    task automatic model_step(input logic e, input logic r, input logic a);
        logic [W-1:0] w;
        logic         acked;
        acked = a && m_valid;
        if (m_fail) begin
        end else if (m_hold) begin
            if (a) begin
                m_word  = m_held;
                m_valid = 1'b1;
                m_hold  = 1'b0;
                m_fill  = e;
                if (!e) m_run = 0;
            end
        end else if (m_fill) begin
            if (!e) begin
                m_fill = 1'b0;
                bits.delete();
                m_run = 0;
                if (acked) m_valid = 1'b0;
            end else begin
                m_run  = (m_run > 0 && r == m_last) ? m_run + 1 : 1;
                m_last = r;
                bits.push_back(r);
                if (m_run >= LIM) begin
                    m_fail  = 1'b1;
                    m_valid = 1'b0;
                    m_word  = '0;
                    sb.delete();
                end else if (bits.size() == W) begin
                    w = '0;
                    for (int i = 0; i < W; i++) w[W-1-i] = bits[i];
                    bits.delete();
                    sb.push_back(w);
                    if (!m_valid || a) begin
                        m_word  = w;
                        m_valid = 1'b1;
                    end else begin
                        m_held = w;
                        m_hold = 1'b1;
                    end
                end else if (acked) begin
                    m_valid = 1'b0;
                end
            end
        end else begin
            if (acked) m_valid = 1'b0;
            if (e) m_fill = 1'b1;
        end
    endtask

    task automatic check_ctrl();
        chk("rd", W'(rd), W'(m_fill && !m_hold && !m_fail));
        chk("mask_valid", W'(mask_valid), W'(m_valid));
        chk("rng_fail", W'(rng_fail), W'(m_fail));
        if (m_fail) chk("fail_mask", mask, '0);
    endtask

    task automatic step(input logic e, input logic r, input logic a);
        en       = e;
        rng_in   = r;
        mask_ack = a;
        model_step(e, r, a);
        @(posedge clk);
        #1;
        check_ctrl();
    endtask

    task automatic do_reset();
        en       = 1'b0;
        mask_ack = 1'b0;
        vrst     = 1'b0;
        #2;
        chk("rst_rd", W'(rd), '0);
        chk("rst_mask", mask, '0);
        chk("rst_mv", W'(mask_valid), '0);
        chk("rst_fail", W'(rng_fail), '0);
        model_reset();
        #1;
        vrst = 1'b1;
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // monitor: a word is consumed on the edge following a negedge with
    // mask_valid && mask_ack
    initial begin
        logic [W-1:0] exp;
        forever begin
            @(negedge clk);
            if (vrst && mask_valid && mask_ack) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got %h want none", mask);
                end else begin
                    exp = sb.pop_front();
                    chk("word", mask, exp);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] alt;
        logic [W-1:0] w1;
        int           fail_at;
        alt      = 64'hAAAA_AAAA_AAAA_AAAA;
        vrst     = 1'b0;
        en       = 1'b0;
        rng_in   = 1'b0;
        mask_ack = 1'b0;
        model_reset();
        #2;
        chk("init_rd", W'(rd), '0);
        chk("init_mask", mask, '0);
        chk("init_mv", W'(mask_valid), '0);
        chk("init_fail", W'(rng_fail), '0);
        @(posedge clk);
        #1;
        vrst = 1'b1;
        step(1'b0, 1'b1, 1'b0);

        // alternating pattern, always acking
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < W; i++) step(1'b1, (i % 2) == 0, 1'b1);
        chk("alt_mv", W'(mask_valid), W'(1));
        chk("alt_mask", mask, alt);
        chk("alt_rd", W'(rd), W'(1));
        step(1'b0, 1'b0, 1'b1);

        // two words without ack -> HOLD, then single ack
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2 * W; i++) step(1'b1, rbit(), 1'b0);
        chk("hold_rd", W'(rd), '0);
        w1 = m_word;
        chk("hold_mask", mask, w1);
        step(1'b1, rbit(), 1'b1);
        chk("hold_rd2", W'(rd), W'(1));
        for (int i = 0; i < 8; i++) step(1'b1, rbit(), 1'b0);
        step(1'b1, rbit(), 1'b1);

        // stuck-at-0 -> FAIL on the 16th sampling edge
        do_reset();
        fail_at = -1;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
            if (rng_fail && fail_at < 0) fail_at = i;
        end
        chk("fail_edge", W'(fail_at), W'(LIM));
        for (int i = 0; i < 10; i++) step(1'b1, rbit(), 1'b1);

        // en dropped after 10 bits, then re-raised
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, rbit(), 1'b0);
        step(1'b0, rbit(), 1'b0);
        chk("drop_rd", W'(rd), '0);
        step(1'b1, rbit(), 1'b0);
        for (int i = 0; i < W; i++) step(1'b1, rbit(), 1'b0);
        step(1'b1, rbit(), 1'b1);

        // async reset mid-FILL and mid-HOLD
        for (int i = 0; i < 20; i++) step(1'b1, rbit(), 1'b0);
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2 * W + 3; i++) step(1'b1, rbit(), 1'b0);
        do_reset();
        step(1'b0, 1'b0, 1'b0);

        // random traffic: spurious acks, coincident completion/ack, en toggles
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 19) != 0, rbit(),
                 1'($urandom_range(0, 2) == 0));
            if (m_fail) do_reset();
        end

        // drain outstanding words
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        chk("drained", W'(sb.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rng_mask_collect.md
RNG_MASK_COLLECT -- requirements
Module: rng_mask_collect

Interface
REQ-001 SHALL have parameter W, default 64, giving the mask word width in bits.
REQ-002 SHALL have parameter RCT_LIMIT, default 16, giving the repetition-count limit in consecutive identical bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port vrst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port en, input, 1, collection enable from the cipher control.
REQ-006 SHALL have port rng_in, input, 1, serial random bit from the generator's rng_out.
REQ-007 SHALL have port rd, output, 1, read strobe to the generator's rd; high requests one bit per cycle.
REQ-008 SHALL have port mask, output, W, the collected mask word presented to the TI share logic.
REQ-009 SHALL have port mask_valid, output, 1, meaning mask holds an unconsumed word.
REQ-010 SHALL have port mask_ack, input, 1, consumer acknowledge; the word is consumed on a rising edge where mask_valid and mask_ack are both 1.
REQ-011 SHALL have port rng_fail, output, 1, sticky health-test failure flag.

Function
REQ-012 SHALL implement states IDLE, FILL, HOLD and FAIL; rd=1 only in FILL.
REQ-013 SHALL sample rng_in on every rising edge at which rd=1, shifting the internal register left: sr <= {sr[W-2:0], rng_in}; the first sampled bit ends at mask MSB.
REQ-014 SHALL go IDLE->FILL on the edge sampling en=1; mask_valid first rises on the (W+1)th edge counting that edge.
REQ-015 SHALL count sampled bits 0..W-1; on the edge sampling bit W-1, the count wraps to 0 and the full word is complete.
REQ-016 On word completion, if the output register is free (mask_valid=0, or mask_ack=1 on that edge), SHALL load mask with the new word, set mask_valid=1, and remain in FILL.
REQ-017 On word completion, if the output register is occupied and not acked, SHALL enter HOLD with the complete word kept in sr, and rd=0.
REQ-018 In HOLD, on mask_ack=1 SHALL load mask from sr and keep mask_valid=1; it SHALL then go to FILL if en=1, else to IDLE.
REQ-019 On mask_ack=1 with no new word loaded on the same edge, SHALL clear mask_valid; mask keeps its value.
REQ-020 SHALL ignore mask_ack while mask_valid=0.
REQ-021 en=0 sampled in FILL SHALL move the block to IDLE, discarding partial bits and clearing the bit count; the held mask/mask_valid are unaffected.
REQ-022 en=0 in HOLD SHALL NOT discard the held word.
REQ-023 SHALL keep a run counter of consecutive identical sampled bits; it is set to 1 on a bit differing from the previous bit, or on the first bit after IDLE, and increments otherwise. It spans word boundaries.
REQ-024 On the edge at which the run counter reaches RCT_LIMIT, SHALL enter FAIL and set rng_fail=1.
REQ-025 In FAIL, SHALL hold rd=0, mask_valid=0 and mask=0, and ignore en and mask_ack; FAIL is left only by vrst.
REQ-026 Run-counter width SHALL be ceil(log2(RCT_LIMIT+1)) bits and SHALL NOT wrap.

Reset
REQ-027 vrst=0 SHALL asynchronously force state IDLE, rd=0, mask=0, mask_valid=0, rng_fail=0, sr=0, bit count=0 and run count=0, with no clock required.
REQ-028 After vrst returns to 1, the first state change SHALL occur on the first rising edge that samples en=1.
REQ-029 vrst asserted mid-FILL or mid-HOLD SHALL discard all collected bits.

Verification
REQ-030 Scenario: reset, then en=1, mask_ack=1, rng_in=1,0,1,0,... -> mask_valid=1 on the 65th edge with mask=64'hAAAA_AAAA_AAAA_AAAA; rd stays 1.
REQ-031 Scenario: mask_ack=0 through two words -> after the second word, rd=0 (HOLD) and mask still holds word 1; one-cycle mask_ack -> mask becomes word 2 and rd=1 on the next cycle.
REQ-032 Scenario: rng_in stuck at 0 after en=1 -> rng_fail=1 on the 16th sampling edge, with rd=0 and mask_valid=0; the state persists with en=1 until vrst=0.
REQ-033 Scenario: en dropped after 10 sampled bits, then re-raised -> rd=0 one cycle later; the next mask_valid requires 64 fresh bits.
REQ-034 Scenario: vrst pulsed low between clock edges during FILL -> all outputs are 0 immediately, before the next edge.
REQ-035 Scenario: mask_ack=1 while mask_valid=0, and word completion coinciding with mask_ack -> the spurious ack has no effect; on the coincident edge mask_valid stays 1 with the new word.
